// File: rtl/ha_acc_pkg.sv
// Shared widths, row struct and row-value helper for the ha_array accumulator.
package ha_acc_pkg;

    localparam int unsigned ROW_W  = 10;
    localparam int unsigned PAIR_W = 13;
    localparam int unsigned SUM_W  = 17;
    localparam int unsigned T_W    = 9;
    localparam int unsigned B_W    = 7;

    typedef struct packed {
        logic [T_W-1:0] t;
        logic [B_W-1:0] b;
    } ha_row_t;

    // Carry row sits two bit positions above its sum row.
    function automatic logic [ROW_W-1:0] row_value(input ha_row_t row);
        return ROW_W'(row.t) + (ROW_W'(row.b) << 2);
    endfunction

endpackage

// File: rtl/ha_acc_pair_merge.sv
// Combinational merge of two adjacent half-adder rows: R_even + (R_odd << 2).
module ha_acc_pair_merge
    import ha_acc_pkg::*;
(
    input  ha_row_t            i_row_even,
    input  ha_row_t            i_row_odd,
    output logic [PAIR_W-1:0]  o_sum
);

    always_comb begin
        o_sum = PAIR_W'(row_value(i_row_even)) + (PAIR_W'(row_value(i_row_odd)) << 2);
    end

endmodule

// File: rtl/ha_array_accumulator_8x8.sv
// Two-stage valid/ready reducer folding four ha_array row pairs into a saturated 16-bit product.
// Optional bias compensation is compiled in with the HA_ACC_ERR_COMP_EN macro.
module ha_array_accumulator_8x8
    import ha_acc_pkg::*;
#(
    parameter logic [15:0] COMP_BIAS = 16'd64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [T_W-1:0]    ha_array_0_t,
    input  logic [T_W-1:0]    ha_array_1_t,
    input  logic [T_W-1:0]    ha_array_2_t,
    input  logic [T_W-1:0]    ha_array_3_t,
    input  logic [B_W-1:0]    ha_array_0_b,
    input  logic [B_W-1:0]    ha_array_1_b,
    input  logic [B_W-1:0]    ha_array_2_b,
    input  logic [B_W-1:0]    ha_array_3_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_product,
    output logic              out_ovf
);

`ifdef HA_ACC_ERR_COMP_EN
    localparam logic [SUM_W-1:0] BIAS_TERM = SUM_W'(COMP_BIAS);
`else
    // Constant zero: the addition folds away and COMP_BIAS has no effect.
    localparam logic [SUM_W-1:0] BIAS_TERM = SUM_W'(COMP_BIAS) & {SUM_W{1'b0}};
`endif

    ha_row_t             w_row0, w_row1, w_row2, w_row3;
    logic [PAIR_W-1:0]   w_pair_a, w_pair_b;
    logic [SUM_W-1:0]    w_sum;
    logic                w_s1_ready, w_s2_ready;

    logic                r_s1_valid;
    logic [PAIR_W-1:0]   r_s1_a, r_s1_b;
    logic                r_out_valid;
    logic [15:0]         r_out_product;
    logic                r_out_ovf;

    assign w_row0 = {ha_array_0_t, ha_array_0_b};
    assign w_row1 = {ha_array_1_t, ha_array_1_b};
    assign w_row2 = {ha_array_2_t, ha_array_2_b};
    assign w_row3 = {ha_array_3_t, ha_array_3_b};

    ha_acc_pair_merge u_merge_a (
        .i_row_even (w_row0),
        .i_row_odd  (w_row1),
        .o_sum      (w_pair_a)
    );

    ha_acc_pair_merge u_merge_b (
        .i_row_even (w_row2),
        .i_row_odd  (w_row3),
        .o_sum      (w_pair_b)
    );

    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_sum      = SUM_W'(r_s1_a) + (SUM_W'(r_s1_b) << 4) + BIAS_TERM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_ovf     <= 1'b0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_a <= w_pair_a;
                    r_s1_b <= w_pair_b;
                end
            end
            if (w_s2_ready) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_product <= w_sum[SUM_W-1] ? 16'hFFFF : w_sum[15:0];
                    r_out_ovf     <= w_sum[SUM_W-1];
                end
            end
        end
    end

    assign in_ready    = w_s1_ready;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_ovf     = r_out_ovf;

endmodule
